tile_matmul_sequencer: RTL
==========================

# tile_matmul_sequencer

Sequences the 8x8 systolic matrix-multiplication engine over a grid of output tiles. For each (row-tile, col-tile) pair it computes BRAM base addresses for A, B and C, pulses start, waits for done, clears done, and advances to the next tile. It sits between the host register file and the engine's `start_reg` / `clear_done_reg` / `address_mat_*` inputs. The engine itself and its BRAMs are unchanged.

## Interface
Parameters:
- AWIDTH, 11, BRAM address width.
- ADDR_STRIDE_WIDTH, 8, stride width passed through to the engine.
- CNT_W, 4, width of the tile counters (up to 16 tiles per dimension).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with SEQ_TIMEOUT_EN).

Ports (clock and reset first):
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; sampled only in IDLE.
- cfg_tiles_m  in  CNT_W  number of row tiles minus 1.
- cfg_tiles_n  in  CNT_W  number of column tiles minus 1.
- cfg_base_a / cfg_base_b / cfg_base_c  in  AWIDTH each  first-tile addresses.
- cfg_inc_a  in  AWIDTH  A address step per row tile.
- cfg_inc_b  in  AWIDTH  B address step per column tile.
- cfg_inc_c  in  AWIDTH  C address step per tile, in linear order.
- cfg_stride_a / cfg_stride_b / cfg_stride_c  in  ADDR_STRIDE_WIDTH each  passed through unchanged.
- mm_done  in  1  engine done level; stays high until cleared.
- mm_start  out  1  start pulse to the engine.
- mm_clear_done  out  1  clear-done level to the engine.
- mm_addr_a / mm_addr_b / mm_addr_c  out  AWIDTH each  current tile addresses.
- mm_stride_a / mm_stride_b / mm_stride_c  out  ADDR_STRIDE_WIDTH each  registered copies of the cfg strides.
- busy  out  1  high from leaving IDLE until reaching DONE.
- seq_done  out  1  high in DONE.
- seq_err  out  1  watchdog fired (exists only with SEQ_TIMEOUT_EN).
- tile_idx  out  2*CNT_W  {row, col} of the current tile.

## Operation
- States: IDLE, ISSUE, WAIT, CLEAR, NEXT, DONE (plus ERR with SEQ_TIMEOUT_EN).
- IDLE:
  - On cfg_start: latch all cfg_* inputs.
  - Set row = col = 0 and addr_a/addr_b/addr_c to the bases.
  - Go to ISSUE.
- ISSUE: assert mm_start for exactly one cycle, then go to WAIT.
- WAIT: stay until mm_done = 1, then go to CLEAR.
- CLEAR: hold mm_clear_done = 1 until mm_done = 0, then go to NEXT.
- NEXT:
  - If col < tiles_n: col += 1, addr_b += inc_b, addr_c += inc_c, then go to ISSUE.
  - Else if row < tiles_m: row += 1, col = 0, addr_a += inc_a, addr_b = base_b, addr_c += inc_c, then go to ISSUE.
  - Otherwise go to DONE.
- Iteration order: column index is the inner loop; row index is the outer loop.
- DONE: hold seq_done = 1. The next cfg_start restarts from the newly sampled cfg values.
- cfg_start outside IDLE/DONE is ignored. cfg inputs may change freely after they are latched.
- Address arithmetic is unsigned and modulo 2^AWIDTH; wrap-around is silent.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately, with no clear issued.
- mm_start rises on the cycle after cfg_start is sampled. mm_addr_* are stable from ISSUE through CLEAR.
- Minimum per-tile overhead, excluding engine time: ISSUE 1 cycle + CLEAR ≥1 cycle + NEXT 1 cycle.
- A single 1x1 tile job (tiles_m = tiles_n = 0) reaches DONE 2 cycles after mm_done falls.
- If mm_done is already high on entry to WAIT, the FSM moves to CLEAR on the next cycle.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT.
  - At TIMEOUT_CYCLES the FSM enters ERR: seq_err = 1, busy = 0, mm_clear_done pulses for 1 cycle.
  - Only cfg_start or reset leaves ERR.
- SEQ_TIMEOUT_EN undefined: no counter, no ERR state, and the seq_err port is absent. WAIT waits indefinitely.

## Structure
- Shared package:
  - State enum.
  - AWIDTH, ADDR_STRIDE_WIDTH and CNT_W defaults.
  - TIMEOUT_CYCLES default.
- One sub-module, `tile_addr_gen`, holds the row/col counters and the three address accumulators. It has step and restart inputs and last_col / last_tile outputs.

## Test plan
- 1x1 job, bases 0/64/128: exactly one mm_start with addresses 0/64/128; seq_done after mm_done is cleared.
- 2x3 job (tiles_m = 1, tiles_n = 2), inc_a = 8, inc_b = 8, inc_c = 16: six starts.
  - mm_addr_c sequence: 128, 144, 160, 176, 192, 208.
  - mm_addr_b resets to its base when the row advances.
- base_c = 2040, inc_c = 16: the second tile's C address wraps to 8.
- Reset asserted in WAIT during tile 3: all outputs 0 next cycle. A new cfg_start restarts from tile (0,0).
- mm_done held high for 5 cycles after clear: FSM stays in CLEAR with mm_clear_done = 1, and no new mm_start is issued.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16, mm_done never rises: seq_err = 1 after 16 WAIT cycles. A subsequent cfg_start clears seq_err.

Source files
------------

// File: rtl/tile_matmul_sequencer_pkg.sv
// rtl/tile_matmul_sequencer_pkg.sv - shared defaults and state encoding for the tile sequencer
package tile_matmul_sequencer_pkg;

    localparam int DEF_AWIDTH            = 11;
    localparam int DEF_ADDR_STRIDE_WIDTH = 8;
    localparam int DEF_CNT_W             = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CLEAR = 3'd3,
        S_NEXT  = 3'd4,
`ifdef SEQ_TIMEOUT_EN
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
`else
        S_DONE  = 3'd5
`endif
    } seq_state_t;

endpackage

// File: rtl/tile_matmul_sequencer_if.sv
// rtl/tile_matmul_sequencer_if.sv - sequencer-to-engine control and address bundle
interface tile_matmul_sequencer_if #(
    parameter int AWIDTH            = 11,
    parameter int ADDR_STRIDE_WIDTH = 8
);
    logic                         mm_start;
    logic                         mm_clear_done;
    logic                         mm_done;
    logic [AWIDTH-1:0]            mm_addr_a;
    logic [AWIDTH-1:0]            mm_addr_b;
    logic [AWIDTH-1:0]            mm_addr_c;
    logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_a;
    logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_b;
    logic [ADDR_STRIDE_WIDTH-1:0] mm_stride_c;

    modport master (
        output mm_start, mm_clear_done, mm_addr_a, mm_addr_b, mm_addr_c,
        output mm_stride_a, mm_stride_b, mm_stride_c,
        input  mm_done
    );

    modport slave (
        input  mm_start, mm_clear_done, mm_addr_a, mm_addr_b, mm_addr_c,
        input  mm_stride_a, mm_stride_b, mm_stride_c,
        output mm_done
    );
endinterface

// File: rtl/tile_matmul_sequencer_tile_addr_gen.sv
// rtl/tile_matmul_sequencer_tile_addr_gen.sv - row/col tile counters and A/B/C address accumulators
module tile_addr_gen #(
    parameter int AWIDTH = 11,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              restart,
    input  logic              step,
    input  logic [AWIDTH-1:0] base_a_i,
    input  logic [AWIDTH-1:0] base_b_i,
    input  logic [AWIDTH-1:0] base_c_i,
    input  logic [AWIDTH-1:0] reload_b_i,
    input  logic [AWIDTH-1:0] inc_a_i,
    input  logic [AWIDTH-1:0] inc_b_i,
    input  logic [AWIDTH-1:0] inc_c_i,
    input  logic [CNT_W-1:0]  tiles_m_i,
    input  logic [CNT_W-1:0]  tiles_n_i,
    output logic [CNT_W-1:0]  row_o,
    output logic [CNT_W-1:0]  col_o,
    output logic [AWIDTH-1:0] addr_a_o,
    output logic [AWIDTH-1:0] addr_b_o,
    output logic [AWIDTH-1:0] addr_c_o,
    output logic              last_col,
    output logic              last_tile
);
    logic [CNT_W-1:0]  row_q, col_q;
    logic [AWIDTH-1:0] addr_a_q, addr_b_q, addr_c_q;

    assign last_col  = (col_q == tiles_n_i);
    assign last_tile = last_col && (row_q == tiles_m_i);

    // Restart takes the raw cfg bases because the top latches cfg on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            row_q    <= '0;
            col_q    <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
        end else if (restart) begin
            row_q    <= '0;
            col_q    <= '0;
            addr_a_q <= base_a_i;
            addr_b_q <= base_b_i;
            addr_c_q <= base_c_i;
        end else if (step) begin
            addr_c_q <= addr_c_q + inc_c_i;
            if (!last_col) begin
                col_q    <= col_q + 1'b1;
                addr_b_q <= addr_b_q + inc_b_i;
            end else begin
                row_q    <= row_q + 1'b1;
                col_q    <= '0;
                addr_a_q <= addr_a_q + inc_a_i;
                addr_b_q <= reload_b_i;
            end
        end
    end

    assign row_o    = row_q;
    assign col_o    = col_q;
    assign addr_a_o = addr_a_q;
    assign addr_b_o = addr_b_q;
    assign addr_c_o = addr_c_q;
endmodule

// File: rtl/tile_matmul_sequencer.sv
// rtl/tile_matmul_sequencer.sv - walks the output-tile grid driving the systolic engine; SEQ_TIMEOUT_EN adds a WAIT watchdog
module tile_matmul_sequencer
    import tile_matmul_sequencer_pkg::*;
#(
    parameter int AWIDTH            = DEF_AWIDTH,
    parameter int ADDR_STRIDE_WIDTH = DEF_ADDR_STRIDE_WIDTH,
    parameter int CNT_W             = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cfg_start,
    input  logic [CNT_W-1:0]             cfg_tiles_m,
    input  logic [CNT_W-1:0]             cfg_tiles_n,
    input  logic [AWIDTH-1:0]            cfg_base_a,
    input  logic [AWIDTH-1:0]            cfg_base_b,
    input  logic [AWIDTH-1:0]            cfg_base_c,
    input  logic [AWIDTH-1:0]            cfg_inc_a,
    input  logic [AWIDTH-1:0]            cfg_inc_b,
    input  logic [AWIDTH-1:0]            cfg_inc_c,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_a,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_b,
    input  logic [ADDR_STRIDE_WIDTH-1:0] cfg_stride_c,
    tile_matmul_sequencer_if.master      mm,
    output logic                         busy,
    output logic                         seq_done,
`ifdef SEQ_TIMEOUT_EN
    output logic                         seq_err,
`endif
    output logic [2*CNT_W-1:0]           tile_idx
);
    seq_state_t state_q, state_d;
    logic load, step, last_col, last_tile;

    logic [CNT_W-1:0]             tiles_m_q, tiles_n_q;
    logic [AWIDTH-1:0]            base_b_q, inc_a_q, inc_b_q, inc_c_q;
    logic [ADDR_STRIDE_WIDTH-1:0] stride_a_q, stride_b_q, stride_c_q;
    logic [CNT_W-1:0]             row, col;

`ifdef SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (cfg_start) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mm.mm_done) begin
                    state_d = S_CLEAR;
`ifdef SEQ_TIMEOUT_EN
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERR;
`endif
                end
            end
            S_CLEAR: begin
                if (!mm.mm_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_tile) begin
                    state_d = S_DONE;
                end else begin
                    step    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
`ifdef SEQ_TIMEOUT_EN
            S_ERR: begin
                if (cfg_start) begin
                    load    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    // Counter holds TIMEOUT_CYCLES only during the first ERR cycle, which times the clear pulse.
    assign wdog_d = (state_q == S_WAIT) ? wdog_q + 1'b1 : '0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tiles_m_q  <= '0;
            tiles_n_q  <= '0;
            base_b_q   <= '0;
            inc_a_q    <= '0;
            inc_b_q    <= '0;
            inc_c_q    <= '0;
            stride_a_q <= '0;
            stride_b_q <= '0;
            stride_c_q <= '0;
`ifdef SEQ_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef SEQ_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
            if (load) begin
                tiles_m_q  <= cfg_tiles_m;
                tiles_n_q  <= cfg_tiles_n;
                base_b_q   <= cfg_base_b;
                inc_a_q    <= cfg_inc_a;
                inc_b_q    <= cfg_inc_b;
                inc_c_q    <= cfg_inc_c;
                stride_a_q <= cfg_stride_a;
                stride_b_q <= cfg_stride_b;
                stride_c_q <= cfg_stride_c;
            end
        end
    end

    tile_addr_gen #(
        .AWIDTH (AWIDTH),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .clk        (clk),
        .resetn     (resetn),
        .restart    (load),
        .step       (step),
        .base_a_i   (cfg_base_a),
        .base_b_i   (cfg_base_b),
        .base_c_i   (cfg_base_c),
        .reload_b_i (base_b_q),
        .inc_a_i    (inc_a_q),
        .inc_b_i    (inc_b_q),
        .inc_c_i    (inc_c_q),
        .tiles_m_i  (tiles_m_q),
        .tiles_n_i  (tiles_n_q),
        .row_o      (row),
        .col_o      (col),
        .addr_a_o   (mm.mm_addr_a),
        .addr_b_o   (mm.mm_addr_b),
        .addr_c_o   (mm.mm_addr_c),
        .last_col   (last_col),
        .last_tile  (last_tile)
    );

    assign mm.mm_start    = (state_q == S_ISSUE);
    assign mm.mm_stride_a = stride_a_q;
    assign mm.mm_stride_b = stride_b_q;
    assign mm.mm_stride_c = stride_c_q;
    assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                            (state_q == S_CLEAR) || (state_q == S_NEXT);
    assign seq_done       = (state_q == S_DONE);
    assign tile_idx       = {row, col};

`ifdef SEQ_TIMEOUT_EN
    assign mm.mm_clear_done = (state_q == S_CLEAR) || ((state_q == S_ERR) && (wdog_q != '0));
    assign seq_err          = (state_q == S_ERR);
`else
    assign mm.mm_clear_done = (state_q == S_CLEAR);
`endif
endmodule
